// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_irq_ctrl
// Description : Memory-mapped machine timer and interrupt controller. Acts as
//               the responder on the core's load/store port and drives the
//               core's interrupt request.
//               - 64-bit mtime with an 8-bit prescaler, 64-bit mtimecmp
//               - N_EXT rising-edge external sources with pending/enable
//               - CLAIM register, IDLE/SVC service FSM closed by an EOI write
// Ports       : clk, reset         clock, synchronous active-high reset
//               cs, wr, addr,      bus select, store/load, byte address,
//               wdata, mask        store data and byte-lane enables
//               rdata              combinational load data (0 when not read)
//               ext_irq            external levels, already in clk domain
//               irq_ack            trap-entry pulse from the core
//               irq                registered interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module timer_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int unsigned N_EXT     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       mask,
    output logic [31:0]      rdata,
    input  logic [N_EXT-1:0] ext_irq,
    input  logic             irq_ack,
    output logic             irq
);

    localparam logic [2:0] c_off_mtime_lo = 3'd0;
    localparam logic [2:0] c_off_mtime_hi = 3'd1;
    localparam logic [2:0] c_off_cmp_lo   = 3'd2;
    localparam logic [2:0] c_off_cmp_hi   = 3'd3;
    localparam logic [2:0] c_off_ctrl     = 3'd4;
    localparam logic [2:0] c_off_pend     = 3'd5;
    localparam logic [2:0] c_off_enable   = 3'd6;
    localparam logic [2:0] c_off_claim    = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SVC  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [63:0]      r_mtime_q,    w_mtime_d;
    logic [7:0]       r_div_q,      w_div_d;
    logic [63:0]      r_cmp_q,      w_cmp_d;
    logic             r_tmr_en_q,   w_tmr_en_d;
    logic             r_tmr_ie_q,   w_tmr_ie_d;
    logic [7:0]       r_prescale_q, w_prescale_d;
    logic [N_EXT-1:0] r_pend_q,     w_pend_d;
    logic [N_EXT-1:0] r_enable_q,   w_enable_d;
    logic [N_EXT-1:0] r_ext_prev_q, w_ext_prev_d;
    state_t           r_state_q,    w_state_d;
    logic             r_irq_q,      w_irq_d;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic        w_hit;
    logic        w_wr_en;
    logic        w_rd_en;
    logic [2:0]  w_off;
    logic [31:0] w_lane;
    logic [31:0] w_wbits;
    logic        w_unused;

    assign w_hit   = (addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr_en = cs & wr & w_hit;
    assign w_rd_en = cs & ~wr & w_hit;
    assign w_off   = addr[4:2];
    assign w_lane  = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    assign w_wbits = wdata & w_lane;
    // Word-aligned register file: the byte offset within a word is irrelevant.
    assign w_unused = ^addr[1:0];

    function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [31:0] lane);
        f_merge = (old_word & ~lane) | (new_word & lane);
    endfunction

    // ------------------------------------------------------------------------
    // Source status and claim
    // ------------------------------------------------------------------------
    logic             w_tmr_pend;
    logic [N_EXT:0]   w_src;
    logic             w_claim_valid;
    logic [4:0]       w_claim_id;
    logic             w_req;
    logic             w_ack_take;
    logic [N_EXT-1:0] w_ack_clr;

    assign w_tmr_pend    = (r_mtime_q >= r_cmp_q);
    assign w_src         = {r_pend_q & r_enable_q, w_tmr_pend & r_tmr_ie_q};
    assign w_claim_valid = |w_src;
    assign w_req         = w_claim_valid;
    // An acknowledge only takes effect when there is something to service.
    assign w_ack_take    = (r_state_q == ST_IDLE) & irq_ack & w_claim_valid;

    always_comb begin
        w_claim_id = 5'd0;
        // Descending scan so the lowest-numbered active source wins.
        for (int i = N_EXT; i >= 0; i--) begin
            if (w_src[i]) begin
                w_claim_id = 5'(i);
            end
        end
    end

    always_comb begin
        w_ack_clr = '0;
        for (int k = 0; k < N_EXT; k++) begin
            w_ack_clr[k] = w_ack_take && (w_claim_id == 5'(k + 1));
        end
    end

    // ------------------------------------------------------------------------
    // Timer: mtime, prescaler divider, compare
    // ------------------------------------------------------------------------
    always_comb begin
        w_mtime_d = r_mtime_q;
        w_div_d   = r_div_q;
        if (w_wr_en && (w_off == c_off_mtime_lo)) begin
            w_mtime_d[31:0] = f_merge(r_mtime_q[31:0], wdata, w_lane);
            w_div_d         = 8'd0;
        end else if (w_wr_en && (w_off == c_off_mtime_hi)) begin
            w_mtime_d[63:32] = f_merge(r_mtime_q[63:32], wdata, w_lane);
            w_div_d          = 8'd0;
        end else if (r_tmr_en_q) begin
            // '>=' rather than '==' so lowering prescale mid-count cannot
            // stall the divider until it wraps.
            if (r_div_q >= r_prescale_q) begin
                w_div_d   = 8'd0;
                w_mtime_d = r_mtime_q + 64'd1;
            end else begin
                w_div_d = r_div_q + 8'd1;
            end
        end else begin
            w_div_d = 8'd0;
        end
    end

    always_comb begin
        w_cmp_d = r_cmp_q;
        if (w_wr_en && (w_off == c_off_cmp_lo)) begin
            w_cmp_d[31:0] = f_merge(r_cmp_q[31:0], wdata, w_lane);
        end else if (w_wr_en && (w_off == c_off_cmp_hi)) begin
            w_cmp_d[63:32] = f_merge(r_cmp_q[63:32], wdata, w_lane);
        end
    end

    // ------------------------------------------------------------------------
    // CTRL and ENABLE registers
    // ------------------------------------------------------------------------
    logic [31:0] w_ctrl_word;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_enable_word;
    logic [31:0] w_enable_new;

    always_comb begin
        w_ctrl_word = {16'h0000, r_prescale_q, 6'b000000, r_tmr_ie_q, r_tmr_en_q};
        w_ctrl_new  = f_merge(w_ctrl_word, wdata, w_lane);
        w_tmr_en_d   = r_tmr_en_q;
        w_tmr_ie_d   = r_tmr_ie_q;
        w_prescale_d = r_prescale_q;
        if (w_wr_en && (w_off == c_off_ctrl)) begin
            w_tmr_en_d   = w_ctrl_new[0];
            w_tmr_ie_d   = w_ctrl_new[1];
            w_prescale_d = w_ctrl_new[15:8];
        end
    end

    always_comb begin
        w_enable_word              = '0;
        w_enable_word[N_EXT:1]     = r_enable_q;
        w_enable_new               = f_merge(w_enable_word, wdata, w_lane);
        w_enable_d                 = r_enable_q;
        if (w_wr_en && (w_off == c_off_enable)) begin
            w_enable_d = w_enable_new[N_EXT:1];
        end
    end

    // ------------------------------------------------------------------------
    // External pending: edge set beats both W1C and acknowledge clear
    // ------------------------------------------------------------------------
    logic [N_EXT-1:0] w_edge;
    logic [N_EXT-1:0] w_w1c;

    assign w_edge       = ext_irq & ~r_ext_prev_q;
    assign w_w1c        = (w_wr_en && (w_off == c_off_pend)) ? w_wbits[N_EXT:1] : '0;
    assign w_pend_d     = (r_pend_q & ~(w_w1c | w_ack_clr)) | w_edge;
    assign w_ext_prev_d = ext_irq;

    // ------------------------------------------------------------------------
    // Service FSM and request register
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_ack_take) begin
                    w_state_d = ST_SVC;
                end
            end
            ST_SVC: begin
                // End-of-interrupt: any store to the CLAIM offset.
                if (w_wr_en && (w_off == c_off_claim)) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        // Mask with the upcoming service state so irq drops right after the
        // acknowledge edge and can return right after the EOI edge.
        w_irq_d = w_req & (w_state_d != ST_SVC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime_q    <= '0;
            r_div_q      <= '0;
            r_cmp_q      <= '1;
            r_tmr_en_q   <= 1'b0;
            r_tmr_ie_q   <= 1'b0;
            r_prescale_q <= '0;
            r_pend_q     <= '0;
            r_enable_q   <= '0;
            r_ext_prev_q <= '0;
            r_state_q    <= ST_IDLE;
            r_irq_q      <= 1'b0;
        end else begin
            r_mtime_q    <= w_mtime_d;
            r_div_q      <= w_div_d;
            r_cmp_q      <= w_cmp_d;
            r_tmr_en_q   <= w_tmr_en_d;
            r_tmr_ie_q   <= w_tmr_ie_d;
            r_prescale_q <= w_prescale_d;
            r_pend_q     <= w_pend_d;
            r_enable_q   <= w_enable_d;
            r_ext_prev_q <= w_ext_prev_d;
            r_state_q    <= w_state_d;
            r_irq_q      <= w_irq_d;
        end
    end

    assign irq = r_irq_q;

    // ------------------------------------------------------------------------
    // Read mux (zero wait states)
    // ------------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0000_0000;
        if (w_rd_en) begin
            case (w_off)
                c_off_mtime_lo: rdata = r_mtime_q[31:0];
                c_off_mtime_hi: rdata = r_mtime_q[63:32];
                c_off_cmp_lo:   rdata = r_cmp_q[31:0];
                c_off_cmp_hi:   rdata = r_cmp_q[63:32];
                c_off_ctrl:     rdata = w_ctrl_word;
                c_off_pend: begin
                    rdata[N_EXT:1] = r_pend_q;
                    rdata[0]       = w_tmr_pend;
                end
                c_off_enable:   rdata = w_enable_word;
                default:        rdata = w_claim_valid ? {27'd0, w_claim_id} : 32'hFFFF_FFFF;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_irq_ctrl
// Description : Self-checking bench for timer_irq_ctrl. Directed scenarios
//               check fixed expected values; a randomized phase compares the
//               DUT against a cycle-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          NE   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    mask;
    logic [31:0]   rdata;
    logic [NE-1:0] ext_irq;
    logic          irq_ack;
    logic          irq;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    timer_irq_ctrl #(
        .BASE_ADDR (BASE),
        .N_EXT     (NE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .mask    (mask),
        .rdata   (rdata),
        .ext_irq (ext_irq),
        .irq_ack (irq_ack),
        .irq     (irq)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp;
    int            m_div;
    logic          m_en;
    logic          m_ie;
    logic [7:0]    m_pre;
    logic [NE-1:0] m_pend;
    logic [NE-1:0] m_enable;
    logic [NE-1:0] m_prev;
    logic          m_svc;
    logic          m_irq;

    function automatic logic [31:0] lanes(input logic [3:0] m);
        lanes = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Lowest enabled-and-pending source, or -1.
    function automatic int m_claim();
        if ((m_mtime >= m_cmp) && m_ie) return 0;
        for (int s = 1; s <= NE; s++) begin
            if (m_pend[s-1] && m_enable[s-1]) return s;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [31:0] t;
        int          cl;
        if (!(cs && !wr && (addr[31:5] == BASE[31:5]))) return 32'h0;
        t = 32'h0;
        case (addr[4:2])
            3'd0: t = m_mtime[31:0];
            3'd1: t = m_mtime[63:32];
            3'd2: t = m_cmp[31:0];
            3'd3: t = m_cmp[63:32];
            3'd4: t = {16'h0, m_pre, 6'h0, m_ie, m_en};
            3'd5: begin t[NE:1] = m_pend; t[0] = (m_mtime >= m_cmp); end
            3'd6: t[NE:1] = m_enable;
            default: begin
                cl = m_claim();
                t  = (cl < 0) ? 32'hFFFF_FFFF : 32'(cl);
            end
        endcase
        return t;
    endfunction

    always @(posedge clk) begin : p_model
        int            cl;
        logic          we;
        logic [2:0]    off;
        logic [31:0]   lm;
        logic [31:0]   wm;
        logic [31:0]   tmp;
        logic [NE-1:0] clr;
        logic          nsvc;
        if (reset) begin
            m_mtime  = 64'h0;
            m_cmp    = {64{1'b1}};
            m_div    = 0;
            m_en     = 1'b0;
            m_ie     = 1'b0;
            m_pre    = 8'h0;
            m_pend   = '0;
            m_enable = '0;
            m_prev   = '0;
            m_svc    = 1'b0;
            m_irq    = 1'b0;
        end else begin
            lm  = lanes(mask);
            wm  = wdata & lm;
            we  = cs && wr && (addr[31:5] == BASE[31:5]);
            off = addr[4:2];
            cl  = m_claim();
            nsvc = m_svc;
            clr  = '0;
            if (!m_svc && irq_ack && (cl >= 0)) begin
                nsvc = 1'b1;
                if (cl > 0) clr[cl-1] = 1'b1;
            end else if (m_svc && we && (off == 3'd7)) begin
                nsvc = 1'b0;
            end
            if (we && (off == 3'd5)) clr = clr | wm[NE:1];
            m_pend = (m_pend & ~clr) | (ext_irq & ~m_prev);
            m_prev = ext_irq;
            // mtime: software write wins and restarts the count
            if (we && (off == 3'd0)) begin
                m_mtime[31:0] = (m_mtime[31:0] & ~lm) | wm;
                m_div = 0;
            end else if (we && (off == 3'd1)) begin
                m_mtime[63:32] = (m_mtime[63:32] & ~lm) | wm;
                m_div = 0;
            end else if (m_en) begin
                m_div = m_div + 1;
                if (m_div > int'(m_pre)) begin
                    m_div   = 0;
                    m_mtime = m_mtime + 64'd1;
                end
            end else begin
                m_div = 0;
            end
            if (we && (off == 3'd2)) m_cmp[31:0]  = (m_cmp[31:0] & ~lm) | wm;
            if (we && (off == 3'd3)) m_cmp[63:32] = (m_cmp[63:32] & ~lm) | wm;
            if (we && (off == 3'd4)) begin
                tmp   = ({16'h0, m_pre, 6'h0, m_ie, m_en} & ~lm) | wm;
                m_en  = tmp[0];
                m_ie  = tmp[1];
                m_pre = tmp[15:8];
            end
            if (we && (off == 3'd6)) begin
                tmp         = 32'h0;
                tmp[NE:1]   = m_enable;
                tmp         = (tmp & ~lm) | wm;
                m_enable    = tmp[NE:1];
            end
            m_irq = (cl >= 0) && !nsvc;
            m_svc = nsvc;
        end
    end

    // ------------------------------------------------------------------------
    // Bus helpers (start and end at a falling edge)
    // ------------------------------------------------------------------------
    task automatic do_reset();
        reset = 1'b1; cs = 1'b0; wr = 1'b0; addr = BASE; wdata = 32'h0;
        mask = 4'h0; ext_irq = '0; irq_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] m);
        addr = BASE | {27'd0, off, 2'b00}; cs = 1'b1; wr = 1'b1; wdata = d; mask = m;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; mask = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
        addr = BASE | {27'd0, off, 2'b00}; cs = 1'b1; wr = 1'b0;
        #1 d = rdata;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ext(input logic [NE-1:0] v);
        ext_irq = v;
        @(negedge clk);
        ext_irq = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] e;
        do_reset();
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            e = (i == 2 || i == 3 || i == 7) ? 32'hFFFF_FFFF : 32'h0;
            n_total++; if (d !== e) $display("FAIL reset_off%0d: got %h want %h", i * 4, d, e); else n_pass++;
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        do_reset();
        bus_write(3'd4, 32'h0000_0301, 4'hF);
        idle(4);
        bus_read(3'd0, d);
        n_total++; if (d !== 32'h1) $display("FAIL prescale_tick1: got %h want 1", d); else n_pass++;
        idle(3);
        bus_read(3'd0, d);
        n_total++; if (d !== 32'h2) $display("FAIL prescale_tick2: got %h want 2", d); else n_pass++;
        bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd1, 32'h0, 4'hF);
        idle(4);
        bus_read(3'd1, d);
        n_total++; if (d !== 32'h1) $display("FAIL prescale_carry_hi: got %h want 1", d); else n_pass++;
        bus_read(3'd0, d);
        n_total++; if (d !== 32'h0) $display("FAIL prescale_carry_lo: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_timer_irq();
        logic [31:0] d;
        do_reset();
        bus_write(3'd3, 32'h0, 4'hF);
        bus_write(3'd2, 32'd10, 4'hF);
        bus_write(3'd4, 32'h3, 4'hF);
        idle(9);
        n_total++; if (irq !== 1'b0) $display("FAIL timer_irq_early9: got %b want 0", irq); else n_pass++;
        idle(1);
        n_total++; if (irq !== 1'b0) $display("FAIL timer_irq_lag: got %b want 0", irq); else n_pass++;
        idle(1);
        n_total++; if (irq !== 1'b1) $display("FAIL timer_irq_set: got %b want 1", irq); else n_pass++;
        bus_read(3'd7, d);
        n_total++; if (d !== 32'h0) $display("FAIL timer_claim: got %h want 0", d); else n_pass++;
        ack();
        n_total++; if (irq !== 1'b0) $display("FAIL timer_ack_drop: got %b want 0", irq); else n_pass++;
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h1) $display("FAIL timer_pend_level: got %h want 1", d); else n_pass++;
        bus_write(3'd2, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd7, 32'h0, 4'hF);
        idle(2);
        n_total++; if (irq !== 1'b0) $display("FAIL timer_after_eoi: got %b want 0", irq); else n_pass++;
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h0) $display("FAIL timer_pend_cleared: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_ext_priority();
        logic [31:0] d;
        do_reset();
        bus_write(3'd6, 32'h6, 4'hF);
        pulse_ext(4'b0011);
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h6) $display("FAIL ext_pend: got %h want 6", d); else n_pass++;
        bus_read(3'd7, d);
        n_total++; if (d !== 32'h1) $display("FAIL ext_claim1: got %h want 1", d); else n_pass++;
        n_total++; if (irq !== 1'b1) $display("FAIL ext_irq_set: got %b want 1", irq); else n_pass++;
        ack();
        n_total++; if (irq !== 1'b0) $display("FAIL ext_ack_drop: got %b want 0", irq); else n_pass++;
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h4) $display("FAIL ext_ack_clear: got %h want 4", d); else n_pass++;
        idle(2);
        n_total++; if (irq !== 1'b0) $display("FAIL ext_svc_hold: got %b want 0", irq); else n_pass++;
        bus_write(3'd7, 32'h1234_5678, 4'h0);
        n_total++; if (irq !== 1'b1) $display("FAIL ext_eoi_reassert: got %b want 1", irq); else n_pass++;
        bus_read(3'd7, d);
        n_total++; if (d !== 32'h2) $display("FAIL ext_claim2: got %h want 2", d); else n_pass++;
    endtask

    task automatic test_byte_mask();
        logic [31:0] d;
        do_reset();
        bus_write(3'd4, 32'h3, 4'hF);
        bus_write(3'd4, 32'hAAAA_0500, 4'b0010);
        bus_read(3'd4, d);
        n_total++; if (d !== 32'h0000_0503) $display("FAIL mask_ctrl: got %h want 00000503", d); else n_pass++;
        bus_write(3'd4, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd4, d);
        n_total++; if (d !== 32'h0000_FF03) $display("FAIL mask_reserved: got %h want 0000ff03", d); else n_pass++;
        bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd6, d);
        n_total++; if (d !== 32'h0000_001E) $display("FAIL enable_reserved: got %h want 0000001e", d); else n_pass++;
        // A store outside the decoded window must not land.
        addr = 32'h0000_0208; cs = 1'b1; wr = 1'b1; wdata = 32'h55; mask = 4'hF;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; mask = 4'h0;
        bus_read(3'd2, d);
        n_total++; if (d !== 32'hFFFF_FFFF) $display("FAIL miss_write: got %h want ffffffff", d); else n_pass++;
    endtask

    task automatic test_corner();
        logic [31:0] d;
        do_reset();
        pulse_ext(4'b0010);
        idle(1);
        ext_irq = 4'b0010;
        bus_write(3'd5, 32'h4, 4'hF);
        ext_irq = '0;
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h4) $display("FAIL w1c_vs_edge: got %h want 4", d); else n_pass++;
        bus_write(3'd5, 32'h5, 4'hF);
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h0) $display("FAIL w1c_plain: got %h want 0", d); else n_pass++;
        // Acknowledge-clear colliding with a new edge on the same source.
        bus_write(3'd6, 32'h2, 4'hF);
        pulse_ext(4'b0001);
        idle(1);
        ext_irq = 4'b0001;
        ack();
        ext_irq = '0;
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h2) $display("FAIL ack_vs_edge: got %h want 2", d); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL svc_irq_low: got %b want 0", irq); else n_pass++;
        // Reset while in service returns to IDLE.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++; if (irq !== 1'b0) $display("FAIL reset_in_svc_irq: got %b want 0", irq); else n_pass++;
        bus_read(3'd5, d);
        n_total++; if (d !== 32'h0) $display("FAIL reset_in_svc_pend: got %h want 0", d); else n_pass++;
        bus_write(3'd6, 32'h2, 4'hF);
        pulse_ext(4'b0001);
        idle(1);
        n_total++; if (irq !== 1'b1) $display("FAIL reset_in_svc_idle: got %b want 1", irq); else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0]  off;
        logic [31:0] e;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            off     = 3'($urandom_range(0, 7));
            cs      = ($urandom_range(0, 3) != 0);
            wr      = ($urandom_range(0, 2) == 0);
            addr    = (($urandom_range(0, 7) == 0) ? 32'h0000_0200 : BASE) | {27'd0, off, 2'b00};
            wdata   = (off <= 3'd3 && $urandom_range(0, 7) != 0) ? 32'($urandom_range(0, 60)) : 32'($urandom);
            if (off == 3'd4) wdata[15:8] = 8'($urandom_range(0, 3));
            mask    = 4'($urandom_range(0, 15));
            ext_irq = NE'($urandom);
            irq_ack = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            #1;
            e = exp_rdata();
            n_total++; if (rdata !== e) $display("FAIL rand_rdata c%0d off%0d: got %h want %h", c, off, rdata, e); else n_pass++;
            n_total++; if (irq !== m_irq) $display("FAIL rand_irq c%0d: got %b want %b", c, irq, m_irq); else n_pass++;
            @(negedge clk);
        end
        reset = 1'b0; cs = 1'b0; wr = 1'b0; irq_ack = 1'b0; ext_irq = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cs = 1'b0; wr = 1'b0; addr = BASE; wdata = 32'h0;
        mask = 4'h0; ext_irq = '0; irq_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_prescale();
        test_timer_irq();
        test_ext_priority();
        test_byte_mask();
        test_corner();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
